// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame path.
//   IMG_W_DEF / IMG_H_DEF : default frame geometry (pixels per line, lines)
//   PIX_W                 : RGB444 pixel width
//   pkt_state_e           : frame_packetizer FSM state encoding
package vga_pkg;
   localparam int IMG_W_DEF = 160;
   localparam int IMG_H_DEF = 120;
   localparam int PIX_W     = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } pkt_state_e;
endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry pixel FIFO sitting between the frame-buffer read port and the
// VGA stage.
//   push/push_data : write one pixel (ignored when full)
//   pop            : remove the head pixel (ignored when empty)
//   head_data      : current head pixel
//   full/empty     : occupancy flags
//   count          : number of stored pixels (0..2)
module pix_skid_fifo
   import vga_pkg::*;
#(
   parameter int W = PIX_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head_data,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   assign full      = (count_q == 2'd2);
   assign empty     = (count_q == 2'd0);
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // Pushing is blocked when full, so a push never lands on the entry being
   // popped in the same cycle.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      count_d = 2'(count_q + {1'b0, do_push} - {1'b0, do_pop});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/frame_packetizer.sv
// Streams one frame out of a frame buffer to the VGA pixel-filter stage.
//   start              : request one frame (ignored while busy)
//   busy               : frame in progress
//   mem_addr/mem_rd    : frame-buffer read port, data returns 1 cycle later
//   mem_data           : returned RGB444 pixel
//   vga_ready          : downstream can accept a pixel
//   out_data/out_valid : pixel stream, transfer when valid & ready
//   start_p/end_p      : first / last pixel markers, qualified by out_valid
//   frame_done         : one-cycle pulse after the last transfer
module frame_packetizer
   import vga_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [PIX_W-1:0]  mem_data,
   input  logic              vga_ready,
   output logic [PIX_W-1:0]  out_data,
   output logic              out_valid,
   output logic              start_p,
   output logic              end_p,
   output logic              frame_done
);
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int CNT_W = $clog2(NPIX + 1);
   localparam logic [CNT_W-1:0] TOTAL = CNT_W'(NPIX);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NPIX - 1);

   pkt_state_e       state_q, state_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;      // reads issued this frame
   logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;  // pixels transferred this frame
   logic             inflight_q;              // read issued last cycle
   logic             frame_done_q, frame_done_d;

   logic             fifo_full, fifo_empty;
   logic [1:0]       fifo_count;
   logic             xfer, rd_ok;
   logic [2:0]       occ;

   assign out_valid  = ~fifo_empty;
   assign xfer       = out_valid & vga_ready;
   assign busy       = (state_q != ST_IDLE);
   assign mem_addr   = ADDR_W'(rd_cnt_q);
   assign start_p    = out_valid & (xfer_cnt_q == '0);
   assign end_p      = out_valid & (xfer_cnt_q == LAST);
   assign frame_done = frame_done_q;

   // Occupancy seen at the end of this cycle: stored pixels plus the read
   // returning now, minus the pixel leaving now. A new read is allowed only
   // if it still leaves room for its own return, which keeps full-rate
   // streaming while never overrunning the two entries.
   assign occ   = 3'({1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, xfer});
   assign rd_ok = (occ < 3'd2) && (rd_cnt_q != TOTAL) && !(fifo_full && !xfer);

   pix_skid_fifo #(.W(PIX_W)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (inflight_q),
      .push_data (mem_data),
      .pop       (xfer),
      .head_data (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d      = state_q;
      mem_rd       = 1'b0;
      frame_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Issue the first read in the start cycle so pixel 0 is at the
            // FIFO head two cycles later.
            if (start) begin
               mem_rd  = rd_ok;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            mem_rd = rd_ok;
            if ((rd_ok && rd_cnt_q == LAST) || rd_cnt_q == TOTAL)
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (xfer && xfer_cnt_q == LAST) begin
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rd_cnt_d   = rd_cnt_q + {{(CNT_W-1){1'b0}}, mem_rd};
      xfer_cnt_d = xfer_cnt_q + {{(CNT_W-1){1'b0}}, xfer};
      if (frame_done_d) begin
         rd_cnt_d   = '0;
         xfer_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         rd_cnt_q     <= '0;
         xfer_cnt_q   <= '0;
         inflight_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_cnt_q     <= rd_cnt_d;
         xfer_cnt_q   <= xfer_cnt_d;
         inflight_q   <= mem_rd;
         frame_done_q <= frame_done_d;
      end
   end
endmodule

// File: tb/tb_frame_packetizer.sv
module tb_frame_packetizer;
   localparam int N = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, busy, mem_rd, vga_ready, out_valid, start_p, end_p, frame_done;
   logic [2:0]  mem_addr;
   logic [11:0] mem_data, out_data;

   logic        s1_start, s1_busy, s1_mem_rd, s1_ready, s1_valid, s1_sp, s1_ep, s1_fd;
   logic [0:0]  s1_addr;
   logic [11:0] s1_mem_data, s1_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   frame_packetizer #(.IMG_W(4), .IMG_H(2), .ADDR_W(3)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .vga_ready(vga_ready), .out_data(out_data), .out_valid(out_valid),
      .start_p(start_p), .end_p(end_p), .frame_done(frame_done)
   );

   frame_packetizer #(.IMG_W(1), .IMG_H(1), .ADDR_W(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(s1_start), .busy(s1_busy),
      .mem_addr(s1_addr), .mem_rd(s1_mem_rd), .mem_data(s1_mem_data),
      .vga_ready(s1_ready), .out_data(s1_out), .out_valid(s1_valid),
      .start_p(s1_sp), .end_p(s1_ep), .frame_done(s1_fd)
   );

   // Frame buffer: pixel at address a is 0x100 + a, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_rd)    mem_data    <= 12'h100 + 12'(mem_addr);
      if (s1_mem_rd) s1_mem_data <= 12'h100 + 12'(s1_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic ready_for(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return (k % 4 == 0) || (k % 4 == 3);
         2:       return k >= 20;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Runs one frame on the 4x2 instance. Expected stream is pixel i = 0x100+i
   // in order, one per accepted handshake, markers on the first/last pixel.
   task automatic run_frame(input int mode, input int restart_px, input int rst_after);
      int idx = 0, rd_n = 0, fd_n = 0, last_k = -10, first_k = -1, stall_rd = 0;
      bit held = 0, restarted = 0, done = 0, rst_now = 0;
      logic [11:0] held_v = '0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         start = (k == 0);
         if (restart_px >= 0 && !restarted && idx == restart_px) begin
            start = 1'b1;
            restarted = 1;
         end
         vga_ready = ready_for(mode, k);
         #1;
         if (frame_done) begin
            fd_n++;
            chk("fd_timing", k, last_k + 1);
            chk("busy_at_fd", busy, 0);
         end
         if (mem_rd) begin
            chk("rd_addr", mem_addr, rd_n);
            rd_n++;
            if (mode == 2 && k < 20) stall_rd++;
         end
         if (mode == 2 && k >= 2 && k < 20) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 12'h100);
         end
         if (out_valid) begin
            if (first_k < 0) first_k = k;
            if (held) chk("hold_data", out_data, held_v);
            chk("data", out_data, 12'h100 + idx);
            chk("start_p", start_p, idx == 0);
            chk("end_p", end_p, idx == N - 1);
            if (vga_ready) begin
               idx++;
               last_k = k;
               held = 0;
               if (rst_after > 0 && idx == rst_after) begin
                  rst_now = 1;
                  done = 1;
               end
            end else begin
               held = 1;
               held_v = out_data;
            end
         end
         if (fd_n > 0 && k >= last_k + 3) done = 1;
      end
      start = 1'b0;
      if (rst_now) begin
         @(negedge clk);
         reset_n = 1'b0;
         #1;
         chk("rst_busy", busy, 0);
         chk("rst_mem_rd", mem_rd, 0);
         chk("rst_valid", out_valid, 0);
         chk("rst_sp", start_p, 0);
         chk("rst_ep", end_p, 0);
         chk("rst_fd", frame_done, 0);
         chk("rst_addr", mem_addr, 0);
         chk("rst_data", out_data, 0);
         @(negedge clk);
         reset_n = 1'b1;
      end else begin
         chk("frame_end_seen", done, 1);
         chk("xfer_count", idx, N);
         chk("fd_count", fd_n, 1);
         chk("rd_count", rd_n, N);
         if (mode == 0) begin
            chk("first_valid_k", first_k, 2);
            chk("back_to_back", last_k, first_k + N - 1);
         end
         if (mode == 2) chk("stall_rd_le2", stall_rd <= 2, 1);
      end
   endtask

   initial begin
      int n1 = 0, fd1 = 0;
      reset_n = 1'b0; start = 1'b0; vga_ready = 1'b0;
      s1_start = 1'b0; s1_ready = 1'b0;
      #12;
      chk("reset_busy", busy, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_mem_rd", mem_rd, 0);
      chk("reset_addr", mem_addr, 0);
      chk("reset_data", out_data, 0);
      chk("reset_fd", frame_done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_frame(0, -1, 0);   // full rate
      run_frame(1, -1, 0);   // ready 1,0,0,1 pattern
      run_frame(2, -1, 0);   // long initial stall
      run_frame(0, 3, 0);    // start re-pulsed mid-frame
      run_frame(0, -1, 5);   // reset after transfer 5
      run_frame(0, -1, 0);   // fresh frame after reset
      repeat (4) run_frame(3, -1, 0);

      // Single-pixel frame: both markers on the only pixel.
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         s1_start = (k == 0);
         s1_ready = 1'b1;
         #1;
         if (s1_fd) fd1++;
         if (s1_valid) begin
            chk("s1_data", s1_out, 12'h100);
            chk("s1_start_p", s1_sp, 1);
            chk("s1_end_p", s1_ep, 1);
            n1++;
         end
      end
      chk("s1_xfers", n1, 1);
      chk("s1_fd_count", fd1, 1);
      chk("s1_idle_busy", s1_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
